// File: rtl/fpu_divider16_pkg.sv
// Shared constants and state encoding for the FP16 mantissa divider.
package fpu_divider16_pkg;

  // Stored fraction width; mantissa operands carry the hidden bit on top.
  localparam int FRACW = 10;
  localparam int MW    = FRACW + 1;
  // Dividend pre-shift that yields guard/round bits in the quotient.
  localparam int SHIFT = 13;
  // Quotient width, also the number of compute iterations.
  localparam int QW    = MW + SHIFT;
  localparam int CW    = $clog2(QW);

  // Legacy-compatible state encoding shared with the FPU sequencer.
  typedef logic [1:0] fpu_divide_state_t;
  localparam fpu_divide_state_t DIV_WAIT = 2'd0;
  localparam fpu_divide_state_t DIV_COMP = 2'd1;
  localparam fpu_divide_state_t DIV_DONE = 2'd2;

endpackage

// File: rtl/fpu_divider_fsm.sv
// Control FSM for the mantissa divider: wait -> compute -> done (held).
module fpu_divider_fsm
  import fpu_divider16_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic zeroDiv,
  input  logic compDone,
  output logic compEn,
  output logic busy,
  output logic done
);

  fpu_divide_state_t state_q, state_d;

  // Next-state decode; start only matters while waiting.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      DIV_WAIT: if (start) state_d = zeroDiv ? DIV_DONE : DIV_COMP;
      DIV_COMP: if (compDone) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_DONE;
      default:  state_d = DIV_WAIT;
    endcase
  end

  // State register; only reset leaves DIV_DONE.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) state_q <= DIV_WAIT;
    else       state_q <= state_d;
  end

  assign compEn = (state_q == DIV_COMP);
  assign busy   = compEn;
  assign done   = (state_q == DIV_DONE);

endmodule

// File: rtl/fpu_divider16.sv
// Sequential restoring divider for FP16 mantissas, one quotient bit per clock, MSB first.
module fpu_divider16
  import fpu_divider16_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic [MW-1:0] divIn1,
  input  logic [MW-1:0] divIn2,
  input  logic          start,
  output logic [QW-1:0] quotient,
  output logic          sticky,
  output logic          divByZero,
  output logic          busy,
  output logic          done
);

  logic [MW-1:0] divisor_q;   // latched divisor
  logic [MW-1:0] rem_q;       // partial remainder R, always < divisor
  logic [QW-1:0] dvd_q;       // dividend shift register D
  logic [CW-1:0] cnt_q;       // iteration counter

  logic          comp_en;
  logic          comp_done;
  logic          zero_div;
  logic          load;

  logic [MW:0]   trial;
  logic [MW+1:0] sub_full;
  logic          sub_unused;
  logic          qbit;
  logic [MW-1:0] rem_d;

  assign zero_div  = (divIn2 == '0);
  assign comp_done = comp_en && (cnt_q == CW'(QW - 1));
  // Start is accepted only in DIV_WAIT, i.e. neither computing nor done.
  assign load      = start && !busy && !done;

  fpu_divider_fsm u_fsm (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .zeroDiv  (zero_div),
    .compDone (comp_done),
    .compEn   (comp_en),
    .busy     (busy),
    .done     (done)
  );

  // Trial subtract: trial + ~divisor + 1; carry out means trial >= divisor.
  always_comb begin
    trial      = {rem_q, dvd_q[QW-1]};
    sub_full   = {1'b0, trial} + {1'b0, ~{1'b0, divisor_q}} + (MW + 2)'(1);
    qbit       = sub_full[MW+1];
    sub_unused = sub_full[MW];
    rem_d      = qbit ? sub_full[MW-1:0] : trial[MW-1:0];
  end

  // Datapath: operand capture on start, one restoring step per compute cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divisor_q <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      sticky    <= 1'b0;
      divByZero <= 1'b0;
    end else if (load) begin
      divisor_q <= divIn2;
      rem_q     <= '0;
      dvd_q     <= {divIn1, {SHIFT{1'b0}}};
      cnt_q     <= '0;
      sticky    <= 1'b0;
      divByZero <= zero_div;
      quotient  <= zero_div ? '1 : '0;
    end else if (comp_en) begin
      rem_q    <= rem_d;
      dvd_q    <= dvd_q << 1;
      quotient <= {quotient[QW-2:0], qbit};
      cnt_q    <= cnt_q + CW'(1);
      // Sticky comes from the remainder produced by the final step.
      if (comp_done) sticky <= |rem_d;
    end
  end

endmodule
